// File: rtl/cbus_sram_bridge.sv
// CBus slave to SRAM bridge with FIXED/INCR/WRAP bursts, timer and zero-read overrides.
// Write beats take 1 cycle, read beats RD_LAT+1 cycles; the master holds the request until the last beat.
module cbus_sram_bridge #(
    parameter int          DATA_W     = 64,
    parameter int          IDX_W      = 26,
    parameter int          RD_LAT     = 1,
    parameter int          TIMER_DIV  = 10000,
    parameter logic [63:0] TIMER_ADDR = 64'h3800bff8,
    parameter logic [63:0] ZERO_ADDR  = 64'h40600008
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                oreq_valid_i,
    input  logic                oreq_is_write_i,
    input  logic [63:0]         oreq_addr_i,
    input  logic [2:0]          oreq_size_i,
    input  logic [DATA_W/8-1:0] oreq_strobe_i,
    input  logic [DATA_W-1:0]   oreq_data_i,
    input  logic [7:0]          oreq_len_i,
    input  logic [1:0]          oreq_burst_i,
    output logic                oresp_ready_o,
    output logic                oresp_last_o,
    output logic [DATA_W-1:0]   oresp_data_o,
    output logic [63:0]         rIdx_o,
    input  logic [DATA_W-1:0]   rdata_i,
    output logic [63:0]         wIdx_o,
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W-1:0]   wmask_o,
    output logic                wen_o,
    output logic                en_o,
    output logic                err_o
);
    localparam int          NB         = DATA_W / 8;
    localparam int          OFF        = $clog2(NB);
    localparam int          TW         = (DATA_W < 64) ? DATA_W : 64;
    localparam logic [1:0]  WAIT_LAST  = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;
    localparam logic [31:0] PRESC_LAST = 32'(TIMER_DIV - 1);
    localparam logic [1:0]  B_FIXED    = 2'd0;
    localparam logic [1:0]  B_INCR     = 2'd1;
    localparam logic [1:0]  B_WRAP     = 2'd2;
    localparam logic [1:0]  B_RSVD     = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t      state_q, state_d;
    logic [7:0]  beat_q, beat_d, len_q, len_d;
    logic [1:0]  wait_q, wait_d, burst_q, burst_d;
    logic [63:0] base_q, base_d, timer_q, timer_d;
    logic [31:0] presc_q, presc_d;
    logic        write_q, write_d, err_q, err_d;

    logic              req_bad;
    logic [63:0]       beat_sum, wrap_mask, beat_addr, idx;
    logic              hit_timer, hit_zero, ready, last;
    logic [DATA_W-1:0] timer_dat;

    // Malformed requests still complete, but as FIXED bursts with the error flag raised.
    always_comb begin
        req_bad = (oreq_burst_i == B_RSVD)
               || (oreq_burst_i != B_FIXED && oreq_size_i != 3'(OFF))
               || (oreq_burst_i == B_WRAP && !(oreq_len_i inside {8'd1, 8'd3, 8'd7, 8'd15}));
    end

    // WRAP keeps the base outside the len+1 word window and wraps the word offset inside it.
    always_comb begin
        beat_sum  = base_q + ({56'd0, beat_q} << OFF);
        wrap_mask = {56'd0, len_q} << OFF;
        case (burst_q)
            B_INCR:  beat_addr = beat_sum;
            B_WRAP:  beat_addr = (base_q & ~wrap_mask) | (beat_sum & wrap_mask);
            default: beat_addr = base_q;
        endcase
        idx            = '0;
        idx[IDX_W-1:0] = beat_addr[IDX_W+OFF-1:OFF];
        hit_timer      = (beat_addr == TIMER_ADDR);
        hit_zero       = (beat_addr == ZERO_ADDR);
        timer_dat         = '0;
        timer_dat[TW-1:0] = timer_q[TW-1:0];
    end

    always_comb begin
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            timer_d = timer_q + 64'd1;
        end else begin
            presc_d = presc_q + 32'd1;
            timer_d = timer_q;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        wait_d  = wait_q;
        base_d  = base_q;
        len_d   = len_q;
        burst_d = burst_q;
        write_d = write_q;
        err_d   = err_q;
        ready   = 1'b0;
        last    = 1'b0;
        wen_o   = 1'b0;
        en_o    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (oreq_valid_i) begin
                    base_d  = oreq_addr_i;
                    len_d   = oreq_len_i;
                    write_d = oreq_is_write_i;
                    burst_d = req_bad ? B_FIXED : oreq_burst_i;
                    err_d   = err_q | req_bad;
                    beat_d  = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                en_o = 1'b1;
                if (write_q) begin
                    wen_o = !(hit_timer || hit_zero);
                    ready = 1'b1;
                end else if (RD_LAT == 0) begin
                    ready = 1'b1;
                end else begin
                    wait_d  = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_q == WAIT_LAST) ready = 1'b1;
                else                     wait_d = wait_q + 2'd1;
            end
            default: state_d = S_IDLE;
        endcase
        if (ready) begin
            last = (beat_q == len_q);
            if (last) begin
                beat_d  = '0;
                state_d = S_IDLE;
            end else begin
                beat_d  = beat_q + 8'd1;
                state_d = S_ISSUE;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            wait_q  <= '0;
            base_q  <= '0;
            len_q   <= '0;
            burst_q <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            presc_q <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
            base_q  <= base_d;
            len_q   <= len_d;
            burst_q <= burst_d;
            write_q <= write_d;
            err_q   <= err_d;
            presc_q <= presc_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NB; i++) wmask_o[i*8 +: 8] = {8{oreq_strobe_i[i]}};
    end

    assign oresp_ready_o = ready;
    assign oresp_last_o  = last;
    assign oresp_data_o  = hit_zero ? '0 : (hit_timer ? timer_dat : rdata_i);
    assign rIdx_o        = (state_q == S_IDLE) ? '0 : idx;
    assign wIdx_o        = rIdx_o;
    assign wdata_o       = oreq_data_i;
    assign err_o         = err_q;

endmodule

// File: tb/tb_cbus_sram_bridge.sv
// Bench for cbus_sram_bridge: instance 0 with RD_LAT=0, instance 1 with RD_LAT=2, both TIMER_DIV=4.
module tb_cbus_sram_bridge;
    localparam int          TDIV    = 4;
    localparam logic [63:0] TIMER_A = 64'h3800bff8;
    localparam logic [63:0] ZERO_A  = 64'h40600008;
    localparam logic [63:0] RAM_A   = 64'h80000000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [2];
    logic        req_vld [2], req_wr [2];
    logic [63:0] req_addr [2], req_dat [2];
    logic [2:0]  req_size [2];
    logic [7:0]  req_strb [2], req_len [2];
    logic [1:0]  req_burst [2];
    logic        rsp_rdy [2], rsp_last [2], wen [2], en [2], err [2];
    logic [63:0] rsp_dat [2], ridx [2], widx [2], wdat [2], wmask [2], sram_rdat [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        cbus_sram_bridge #(
            .DATA_W(64), .IDX_W(26), .RD_LAT(2 * g), .TIMER_DIV(TDIV),
            .TIMER_ADDR(TIMER_A), .ZERO_ADDR(ZERO_A)
        ) u_dut (
            .clk_i(clk), .reset_i(rst[g]),
            .oreq_valid_i(req_vld[g]), .oreq_is_write_i(req_wr[g]), .oreq_addr_i(req_addr[g]),
            .oreq_size_i(req_size[g]), .oreq_strobe_i(req_strb[g]), .oreq_data_i(req_dat[g]),
            .oreq_len_i(req_len[g]), .oreq_burst_i(req_burst[g]),
            .oresp_ready_o(rsp_rdy[g]), .oresp_last_o(rsp_last[g]), .oresp_data_o(rsp_dat[g]),
            .rIdx_o(ridx[g]), .rdata_i(sram_rdat[g]), .wIdx_o(widx[g]), .wdata_o(wdat[g]),
            .wmask_o(wmask[g]), .wen_o(wen[g]), .en_o(en[g]), .err_o(err[g])
        );
    end

    // SRAM stand-in shared by both instances; unread cycles return a poison pattern.
    logic [63:0] mem [256];
    logic [63:0] pipe1, pipe2;
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++)
            if (wen[d]) mem[widx[d][7:0]] <= (mem[widx[d][7:0]] & ~wmask[d]) | (wdat[d] & wmask[d]);
        pipe1 <= en[1] ? mem[ridx[1][7:0]] : 64'hBAD0_BAD0_BAD0_BAD0;
        pipe2 <= pipe1;
    end
    assign sram_rdat[0] = en[0] ? mem[ridx[0][7:0]] : 64'hBAD0_BAD0_BAD0_BAD0;
    assign sram_rdat[1] = pipe2;

    int cyc [2];
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) cyc[d] <= rst[d] ? 0 : cyc[d] + 1;
    end

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [63:0] ref_mem [256];
    bit          err_exp [2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] expand(input logic [7:0] s);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = {8{s[i]}};
        return r;
    endfunction

    function automatic logic [63:0] model_addr(input logic [63:0] base, input int b, input int ln, input int bt);
        logic [63:0] word, n;
        word = base / 8;
        n    = 64'(ln + 1);
        case (bt)
            1:       return base + 64'(b) * 8;
            2:       return ((word / n) * n + (word % n + 64'(b)) % n) * 8 + base % 8;
            default: return base;
        endcase
    endfunction

    task automatic rst_dut(input int d);
        @(negedge clk);
        rst[d] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst[d]     = 1'b0;
        err_exp[d] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic run_burst(input int d, input bit w, input logic [63:0] base, input int sz,
                             input int ln, input int bt, input int st, input int abort_at);
        int          lat, cycles, ebt;
        bit          bad, wen_exp;
        logic [63:0] a, ix, rd_exp;
        logic [7:0]  s;
        lat = (d == 1 && !w) ? 2 : 0;
        bad = (bt == 3) || (bt != 0 && sz != 3) || (bt == 2 && !(ln == 1 || ln == 3 || ln == 7 || ln == 15));
        ebt = bad ? 0 : bt;
        if (bad) err_exp[d] = 1'b1;
        req_vld[d] = 1'b1; req_wr[d] = w; req_addr[d] = base; req_size[d] = 3'(sz);
        req_len[d] = 8'(ln); req_burst[d] = 2'(bt);
        for (int b = 0; b <= ln; b++) begin
            s = (st < 0) ? 8'($urandom) : 8'(st);
            req_strb[d] = s;
            req_dat[d]  = {$urandom, $urandom};
            cycles = 0;
            do begin
                @(negedge clk);
                cycles++;
            end while (!rsp_rdy[d] && cycles < 16);
            chk("beat_latency", 64'(cycles), 64'((b == 0) ? lat + 2 : lat + 1));
            if (b == abort_at) begin
                rst[d] = 1'b1;
                #1;
                chk("abort_wen", wen[d], 0);
                chk("abort_rdy", rsp_rdy[d], 0);
                chk("abort_err", err[d], 0);
                req_vld[d] = 1'b0;
                err_exp[d] = 1'b0;
                @(posedge clk);
                @(negedge clk);
                rst[d] = 1'b0;
                @(posedge clk);
                #1;
                return;
            end
            a  = model_addr(base, b, ln, ebt);
            ix = (a / 8) & 64'h3FF_FFFF;
            chk("last", rsp_last[d], b == ln);
            chk("ridx", ridx[d], ix);
            chk("widx", widx[d], ix);
            chk("en", en[d], w || lat == 0);
            if (w) begin
                wen_exp = !(a == TIMER_A || a == ZERO_A);
                chk("wen", wen[d], wen_exp);
                chk("wmask", wmask[d], expand(s));
                chk("wdata", wdat[d], req_dat[d]);
                if (wen_exp) ref_mem[ix[7:0]] = (ref_mem[ix[7:0]] & ~expand(s)) | (req_dat[d] & expand(s));
            end else begin
                chk("wen_rd", wen[d], 0);
                if (a == ZERO_A)       rd_exp = '0;
                else if (a == TIMER_A) rd_exp = 64'(cyc[d] / TDIV);
                else                   rd_exp = ref_mem[ix[7:0]];
                chk("rdata", rsp_dat[d], rd_exp);
            end
            @(posedge clk);
            #1;
        end
        req_vld[d] = 1'b0;
        chk("err_flag", err[d], err_exp[d]);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req_vld[d] = 1'b0; req_wr[d] = 1'b0; req_addr[d] = '0; req_dat[d] = '0;
            req_size[d] = 3'd3; req_strb[d] = '0; req_len[d] = '0; req_burst[d] = '0; err_exp[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", rsp_rdy[d], 0);
            chk("rst_last", rsp_last[d], 0);
            chk("rst_wen", wen[d], 0);
            chk("rst_en", en[d], 0);
            chk("rst_ridx", ridx[d], 0);
            chk("rst_widx", widx[d], 0);
            chk("rst_err", err[d], 0);
        end
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(posedge clk);
        #1;

        for (int k = 0; k < 8; k++) run_burst(0, 1'b1, RAM_A + 64'(k * 128), 3, 15, 1, 8'hFF, -1);

        run_burst(0, 1'b0, 64'h80000010, 3, 0, 0, -1, -1);
        run_burst(0, 1'b1, RAM_A, 3, 3, 1, 8'h0F, -1);
        run_burst(1, 1'b0, RAM_A, 3, 1, 1, -1, -1);
        run_burst(0, 1'b0, 64'h80000018, 3, 3, 2, -1, -1);
        run_burst(0, 1'b0, 64'h80000018, 3, 2, 2, -1, -1);
        rst_dut(0);

        rst_dut(0);
        repeat (18) @(posedge clk);
        #1;
        run_burst(0, 1'b0, TIMER_A, 3, 0, 0, -1, -1);
        run_burst(0, 1'b0, ZERO_A, 3, 0, 0, -1, -1);
        run_burst(0, 1'b1, TIMER_A, 3, 0, 0, -1, -1);
        run_burst(0, 1'b1, ZERO_A, 3, 0, 0, -1, -1);
        run_burst(1, 1'b0, TIMER_A, 3, 0, 0, -1, -1);
        run_burst(1, 1'b0, ZERO_A, 3, 0, 0, -1, -1);

        run_burst(0, 1'b1, RAM_A + 64'h200, 3, 7, 1, -1, 2);
        run_burst(0, 1'b0, RAM_A + 64'h200, 3, 7, 1, -1, -1);
        run_burst(0, 1'b1, RAM_A + 64'h200, 3, 7, 1, -1, -1);
        run_burst(1, 1'b0, RAM_A + 64'h200, 3, 7, 1, -1, -1);

        for (int d = 0; d < 2; d++) begin
            for (int it = 0; it < 40; it++) begin
                int          bt, ln, sz, word;
                bit          w;
                logic [63:0] base;
                w  = 1'($urandom_range(0, 1));
                bt = ($urandom_range(0, 11) == 0) ? 3 : int'($urandom_range(0, 2));
                sz = ($urandom_range(0, 9) == 0) ? 2 : 3;
                if (bt == 2) ln = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : (2 << $urandom_range(0, 3)) - 1;
                else         ln = int'($urandom_range(0, 15));
                word = int'($urandom_range(0, 127 - ln));
                base = RAM_A + 64'(word * 8) + 64'($urandom_range(0, 7));
                run_burst(d, w, base, sz, ln, bt, -1, -1);
                if (err_exp[d]) rst_dut(d);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cbus_sram_bridge.md
Name: cbus_sram_bridge

Overview:
- Parametrised CBus-slave-to-SRAM bridge. Connects the CBus arbiter output to a simulation RAM helper or a synchronous SRAM macro.
- Supports FIXED, INCR and WRAP bursts, configurable data width, and configurable SRAM read latency.
- Provides two memory-mapped overrides: a zero-reading status register and a free-running prescaled timer.
- Replaces the fixed 64-bit, zero-latency, INCR-only bridge in the SoC top.

Parameters:
- DATA_W, 64, data/beat width in bits; power of two, 32..128.
- IDX_W, 26, SRAM word-index bits taken from the address above the byte offset.
- RD_LAT, 1, SRAM read latency in cycles, 0..3.
- TIMER_DIV, 10000, clock cycles per timer tick.
- TIMER_ADDR, 64'h3800bff8, address whose reads return the timer.
- ZERO_ADDR, 64'h40600008, address whose reads return 0.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- oreq  in  cbus_req_t  valid, is_write, addr, size, strobe (DATA_W/8), data (DATA_W), len (8), burst (2); held stable until last beat accepted
- oresp  out  cbus_resp_t  ready, last, data (DATA_W)
- rIdx  out  64  SRAM read word index
- rdata  in  DATA_W  SRAM read data, valid RD_LAT cycles after rIdx/en
- wIdx  out  64  SRAM write word index (equals rIdx)
- wdata  out  DATA_W  write data, = oreq.data
- wmask  out  DATA_W  bit mask, each strobe bit expanded to 8 bits
- wen  out  1  write enable
- en  out  1  SRAM enable
- err  out  1  sticky protocol-error flag

Behaviour:
- Reset (async): state=IDLE, beat=0, wait=0, timer and prescaler=0, err=0. Outputs oresp.ready=0, oresp.last=0, wen=0, en=0, all indices 0.
- OFF=log2(DATA_W/8). Beat address A is:
  - FIXED: base.
  - INCR: base + beat*(DATA_W/8).
  - WRAP: base with bits [OFF+log2(len+1)-1:OFF] replaced by (base word + beat) modulo (len+1).
- Index = zero-extended A[IDX_W+OFF-1:OFF].
- FSM IDLE -> ISSUE when oreq.valid. Burst fields and base are captured in that cycle; the request is not re-sampled mid-burst.
- ISSUE, write:
  - wen=1, en=1 for the current beat; oresp.ready=1 in the same cycle.
  - wen is forced to 0 when A equals TIMER_ADDR or ZERO_ADDR; ready is still given.
- ISSUE, read, RD_LAT=0: ready=1 in the same cycle with data.
- ISSUE, read, RD_LAT>0: en=1, go to WAIT. WAIT holds the index for RD_LAT cycles and asserts ready in the last WAIT cycle.
- Each read beat takes RD_LAT+1 cycles; there is no read pipelining.
- On ready: oresp.last=(beat==len).
  - If last: go to IDLE with beat=0.
  - Otherwise: beat+1 and return to ISSUE.
- IDLE outputs ready=0. A new request is accepted in the cycle after last, so back-to-back bursts have exactly one idle cycle between them.
- Read data: oresp.data = 0 if A==ZERO_ADDR; timer zero-extended or truncated to DATA_W if A==TIMER_ADDR; else rdata. Valid only while ready=1.
- Timer: prescaler counts 0..TIMER_DIV-1. On wrap, prescaler returns to 0 and the 64-bit timer increments, wrapping at 2^64. It runs regardless of bus activity.
- Error cases set err (sticky until reset); each burst is executed as FIXED:
  - burst==2'b11.
  - INCR/WRAP with size != OFF.
  - WRAP with len+1 not in {2,4,8,16}.
- Simultaneous events: a valid request in the same cycle reset deasserts is ignored and sampled from the next cycle.
- Reset asserted mid-burst aborts immediately: wen drops asynchronously and no further beats are issued.
- len=0 is a single-beat burst; last is asserted with the first ready.

Test Plan:
- DATA_W=64, RD_LAT=0, FIXED read at 0x80000010 -> rIdx=0x2, ready=last=1 in ISSUE cycle, data=rdata.
- INCR write, len=3, base 0x80000000, strobe 0x0F -> wen on 4 consecutive cycles, wIdx 0..3, wmask=0x00000000FFFFFFFF, last on the 4th beat only.
- RD_LAT=2, INCR read, len=1 -> ready 3 cycles after issue per beat, beats 3 cycles apart, last on the second ready.
- WRAP read, len=3, base 0x80000018 -> rIdx sequence 3,0,1,2, err stays 0. Same burst with len=2 -> err=1, rIdx 3,3,3.
- TIMER_DIV=4, read TIMER_ADDR after 20 cycles from reset -> data=5. Read ZERO_ADDR -> 0. Write TIMER_ADDR -> wen=0, ready=1.
- Assert reset during beat 2 of an INCR write, len=7 -> wen=0 immediately, state IDLE, err=0, and a new burst completes normally afterwards.
